// File: rtl/code_loader.sv
// Purpose  : framed byte-stream programmer; writes big-endian 16-bit words into
//            user code memory and protects the BIOS region below USER_BASE.
// Latency  : 2 header cycles + 3 cycles per word with byte_valid held; done one
//            cycle after the last write.
// Backpres.: byte_ready is decoded from state only; the FSM waits while byte_valid is low.
// Ports    : clock/reset (async active-high); start/abort control; byte_in/
//            byte_valid/byte_ready stream; c1/write_select/inp memory write port;
//            busy/done/error/words_written status.
module code_loader #(
  parameter int unsigned USER_BASE = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        c1,
  output logic [5:0]  write_select,
  output logic [15:0] inp,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [6:0]  words_written
);

  localparam logic [6:0] USER_BASE_7 = 7'(USER_BASE);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_ADDR, S_HDR_CNT, S_DATA_HI, S_DATA_LO, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  base_q, base_d;
  logic [5:0]  addr_q, addr_d;
  logic [6:0]  rem_q, rem_d;
  logic [15:0] inp_q, inp_d;
  logic [5:0]  ws_q, ws_d;
  logic [6:0]  ww_q, ww_d;
  logic        done_q, done_d;

  logic       xfer;
  logic [8:0] end_addr;
  logic       hdr_bad;

  // Outputs decoded purely from state so nothing on the stream side reaches them.
  assign byte_ready    = (state_q == S_HDR_ADDR) || (state_q == S_HDR_CNT) ||
                         (state_q == S_DATA_HI)  || (state_q == S_DATA_LO);
  assign busy          = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
  assign c1            = (state_q == S_WRITE);
  assign error         = (state_q == S_ERROR);
  assign done          = done_q;
  assign write_select  = ws_q;
  assign inp           = inp_q;
  assign words_written = ww_q;

  assign xfer = byte_valid && byte_ready;

  // Widened sum so a large count cannot wrap into an apparently legal range.
  assign end_addr = {3'b000, base_q} + {1'b0, byte_in};
  assign hdr_bad  = (byte_in == 8'd0) || (byte_in > 8'd64) ||
                    ({1'b0, base_q} < USER_BASE_7) || (end_addr > 9'd64);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    inp_d   = inp_q;
    ws_d    = ws_q;
    ww_d    = ww_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      // The write in progress this cycle still lands, so count it.
      if (state_q == S_WRITE) ww_d = ww_q + 7'd1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_d = S_HDR_ADDR;
            ww_d    = 7'd0;
          end
        end
        S_HDR_ADDR: begin
          if (xfer) begin
            base_d  = byte_in[5:0];
            state_d = (byte_in[7:6] != 2'b00) ? S_ERROR : S_HDR_CNT;
          end
        end
        S_HDR_CNT: begin
          if (xfer) begin
            if (hdr_bad) begin
              state_d = S_ERROR;
            end else begin
              addr_d  = base_q;
              rem_d   = byte_in[6:0];
              state_d = S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            inp_d[15:8] = byte_in;
            state_d     = S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            inp_d[7:0] = byte_in;
            ws_d       = addr_q;
            state_d    = S_WRITE;
          end
        end
        S_WRITE: begin
          // After address 63 the counter wraps, but no further write can follow.
          addr_d = addr_q + 6'd1;
          ww_d   = ww_q + 7'd1;
          rem_d  = rem_q - 7'd1;
          if (rem_q == 7'd1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DATA_HI;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      inp_q   <= '0;
      ws_q    <= '0;
      ww_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      inp_q   <= inp_d;
      ws_q    <= ws_d;
      ww_q    <= ww_d;
      done_q  <= done_d;
    end
  end

endmodule
